// File: rtl/fwd_pkg.sv
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared forwarding constants, width helper and tracker slot record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam int FWD_SEL_RF    = 0;
    // Slot fields are sized for the largest supported configuration.
    localparam int FWD_REG_W_MAX = 8;
    localparam int FWD_LAT_W_MAX = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [FWD_REG_W_MAX-1:0] rd;
        logic [FWD_LAT_W_MAX-1:0] lat;
    } fwd_slot_t;

endpackage

`default_nettype wire

// File: rtl/fwd_lookup.sv
// ============================================================================
// Module   : fwd_lookup
// Purpose  : Priority match of one source register against the in-flight slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int LAT_W   = 2,
    parameter int MAX_LAT = 2
) (
    input  logic [REG_W-1:0]               src_i,
    input  logic                           used_i,
    input  fwd_slot_t [MAX_LAT-1:0]        slots_i,
    output logic [LAT_W-1:0]               sel_o,
    output logic                           not_ready_o
);

    logic w_found;

    // Youngest slot wins; once matched, older slots are ignored even if ready.
    always_comb begin
        sel_o       = LAT_W'(FWD_SEL_RF);
        not_ready_o = 1'b0;
        w_found     = 1'b0;
        if (used_i && (src_i != '0)) begin
            for (int p = 0; p < MAX_LAT; p++) begin
                if (!w_found && slots_i[p].valid &&
                    (slots_i[p].rd == FWD_REG_W_MAX'(src_i))) begin
                    w_found = 1'b1;
                    if ((p + 1) >= int'(slots_i[p].lat)) begin
                        sel_o = LAT_W'(p + 1);
                    end else begin
                        not_ready_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : In-flight writer tracker, load-use interlock and EX forward selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int NUM_SRC  = 2,
    parameter  int MAX_LAT  = 2,
    localparam int REG_W    = clog2(NUM_REGS),
    localparam int LAT_W    = clog2(MAX_LAT + 1),
    localparam int SEL_W    = LAT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     id_valid_i,
    input  logic [NUM_SRC*REG_W-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]       id_src_used_i,
    input  logic                     id_regwrite_i,
    input  logic [REG_W-1:0]         id_rd_i,
    input  logic [LAT_W-1:0]         id_lat_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_o
);

    fwd_slot_t [MAX_LAT-1:0]    r_slots_q;
    fwd_slot_t [MAX_LAT-1:0]    w_slots_d;
    logic [NUM_SRC*SEL_W-1:0]   r_ex_fwd_sel_q;
    logic [NUM_SRC*SEL_W-1:0]   w_ex_fwd_sel_d;
    logic [NUM_SRC*SEL_W-1:0]   w_sel;
    logic [NUM_SRC-1:0]         w_not_ready;
    logic                       w_stall;
    logic                       w_issue;
    logic [FWD_LAT_W_MAX-1:0]   w_lat_clamped;

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_lookup
            fwd_lookup #(
                .REG_W   (REG_W),
                .LAT_W   (LAT_W),
                .MAX_LAT (MAX_LAT)
            ) u_lookup (
                .src_i       (id_src_i[k*REG_W +: REG_W]),
                .used_i      (id_src_used_i[k]),
                .slots_i     (r_slots_q),
                .sel_o       (w_sel[k*SEL_W +: SEL_W]),
                .not_ready_o (w_not_ready[k])
            );
        end
    endgenerate

    always_comb begin
        w_stall = id_valid_i & ~flush_i & (|w_not_ready);
        w_issue = id_valid_i & ~w_stall & ~flush_i;

        if (id_lat_i == '0) begin
            w_lat_clamped = FWD_LAT_W_MAX'(1);
        end else if (int'(id_lat_i) > MAX_LAT) begin
            w_lat_clamped = FWD_LAT_W_MAX'(MAX_LAT);
        end else begin
            w_lat_clamped = FWD_LAT_W_MAX'(id_lat_i);
        end

        // Slot 0 takes the issuing writer or a bubble; older slots shift down.
        w_slots_d          = '0;
        w_slots_d[0].valid = w_issue & id_regwrite_i & (id_rd_i != '0);
        w_slots_d[0].rd    = FWD_REG_W_MAX'(id_rd_i);
        w_slots_d[0].lat   = w_lat_clamped;
        for (int p = 1; p < MAX_LAT; p++) begin
            w_slots_d[p] = r_slots_q[p-1];
        end

        w_ex_fwd_sel_d = w_issue ? w_sel : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_slots_q      <= '0;
            r_ex_fwd_sel_q <= '0;
        end else begin
            r_slots_q      <= w_slots_d;
            r_ex_fwd_sel_q <= w_ex_fwd_sel_d;
        end
    end

    assign stall_o      = w_stall;
    assign ex_fwd_sel_o = r_ex_fwd_sel_q;

endmodule

`default_nettype wire
